mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single-port block_ram between three requesters: UART program loader (P0), core data load/store (P1), core instruction fetch (P2).
- Owns the boot sequence. Fetch is held off until the loader signals completion; after that, data and fetch share the RAM with anti-starvation.
- Sits between core/loader and block_ram. It replaces the state-based address mux.

Parameters:
- ADDR_W, 15, RAM word-address width; ram_addr = req addr[ADDR_W+1:2].
- RD_LAT, 1, RAM read latency in cycles (1..3).
- STARVE_MAX, 4, consecutive fetch denials before fetch wins priority once.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- load_done  input  1  one-cycle pulse from loader; ends BOOT
- boot  output  1  1 while in BOOT mode
- pN_req  input  1  request, N=0,1,2
- pN_we  input  1  write enable (ignored for P2; fetch is read-only)
- pN_addr  input  32  byte address, word aligned
- pN_wdata  input  32  write data (P0, P1 only)
- pN_gnt  output  1  access accepted this cycle (combinational)
- pN_rvalid  output  1  read data valid for port N
- pN_rdata  output  32  read data, equals ram_rdata, qualified by pN_rvalid
- ram_en, ram_we  output  1  RAM enable / write enable
- ram_addr  output  ADDR_W  RAM word address
- ram_wdata  output  32  RAM write data
- ram_rdata  input  32  RAM read data

Behaviour:
- Reset (rstn low, asynchronous):
  - mode = BOOT; starve counter = 0; tag pipeline cleared.
  - All gnt, rvalid, ram_en and ram_we are 0; boot = 1.
- Mode FSM:
  - BOOT -> RUN on load_done.
  - RUN is terminal until reset.
  - load_done while already in RUN is ignored.
  - In BOOT, only P0 may be granted; P1 and P2 are never granted.
  - In RUN, P0 is never granted.
- At most one grant per cycle.
  - When a grant occurs: ram_en = 1, ram_we = granted port's we (0 for P2), ram_addr and ram_wdata come from the granted port.
  - With no request: ram_en = 0, ram_we = 0.
- Priority in RUN:
  - P1 beats P2 by default.
  - Starve counter increments each cycle P2 requests but is not granted.
  - Starve counter saturates at STARVE_MAX and clears whenever P2 is granted.
  - When the counter == STARVE_MAX and P2 requests, P2 wins over P1 for that cycle.
- Requesters hold req, addr and data stable until gnt is seen. gnt=1 consumes exactly one access.
- Read return:
  - Each granted read pushes a port tag into an RD_LAT-deep shift pipeline.
  - pN_rvalid is asserted exactly RD_LAT cycles after the grant cycle, for one cycle.
  - Writes produce no rvalid.
- Back-to-back reads from different ports are fully pipelined. Rvalids return in grant order, one per cycle.
- Mode change with reads outstanding: the tag pipeline is not flushed, so the pending P0 rvalid still arrives.
- Misaligned addresses (addr[1:0] != 0): low bits are dropped, no error is raised.
- Reset mid-read: the pending rvalid is dropped.

Optional Feature:
- ARB_STATS_EN defined:
  - Adds outputs stat_gnt1, stat_gnt2 and stat_stall2 (each 32 bits).
  - stat_gnt1 / stat_gnt2 count grants to P1 / P2 in RUN.
  - stat_stall2 counts cycles where P2 requested but was not granted.
  - All counters wrap at 2^32 and reset to 0.
- ARB_STATS_EN undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then P1/P2 req=1 in BOOT -> no gnt, boot=1. P0 write addr 0x8 data 0xDEADBEEF -> p0_gnt=1, ram_we=1, ram_addr=2 in the same cycle.
- load_done pulse, then P2 read addr 0x8 -> boot=0, p2_gnt=1, p2_rvalid exactly RD_LAT cycles later with p2_rdata=0xDEADBEEF. P0 req after this is never granted.
- RUN: P1 and P2 request continuously, STARVE_MAX=4 -> P1 granted 4 cycles, P2 granted on the 5th, then the pattern repeats (P2 gets 1 of every 5 grants).
- Alternating P1 read 0x10 / P2 read 0x14 on consecutive cycles -> rvalids alternate p1/p2 on consecutive cycles, in grant order, each with correct data.
- rstn dropped one cycle after a P2 read grant -> no p2_rvalid, boot=1, all gnt=0 immediately (asynchronous).
- With ARB_STATS_EN: 10 P1 grants and 3 P2 stall cycles -> stat_gnt1=10, stat_stall2=3.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: boot-aware arbiter that shares one single-port block RAM between the
// UART loader (P0), core data (P1) and core fetch (P2). `define ARB_STATS_EN adds stat counters.
module mem_arbiter #(
   parameter int ADDR_W     = 15,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load_done,
   output logic              boot,

   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [31:0]       p0_addr,
   input  logic [31:0]       p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [31:0]       p0_rdata,

   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [31:0]       p1_addr,
   input  logic [31:0]       p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [31:0]       p1_rdata,

   input  logic              p2_req,
   input  logic              p2_we,
   input  logic [31:0]       p2_addr,
   input  logic [31:0]       p2_wdata,
   output logic              p2_gnt,
   output logic              p2_rvalid,
   output logic [31:0]       p2_rdata,

   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]       stat_gnt1,
   output logic [31:0]       stat_gnt2,
   output logic [31:0]       stat_stall2
`endif
);

   localparam logic MODE_BOOT = 1'b0;
   localparam logic MODE_RUN  = 1'b1;

   localparam int              SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

   logic            r_mode;
   logic [SW-1:0]   r_starve;
   logic [2:0]      r_tag [RD_LAT];

   logic [2:0]      w_gnt;
   logic            w_p2_prio;
   logic            w_rd_push;
   logic            w_unused;

   assign w_p2_prio = (r_starve == STARVE_LIM);

   // Grant is gated by rstn so an asserted reset silences the RAM port immediately.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      w_gnt     = 3'b000;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;

      if (rstn) begin
         if (r_mode == MODE_BOOT) begin
            if (p0_req) w_gnt = 3'b001;
         end else if (p2_req && (!p1_req || w_p2_prio)) begin
            w_gnt = 3'b100;
         end else if (p1_req) begin
            w_gnt = 3'b010;
         end
      end

      if (w_gnt[0]) begin
         ram_en    = 1'b1;
         ram_we    = p0_we;
         ram_addr  = p0_addr[ADDR_W+1:2];
         ram_wdata = p0_wdata;
      end else if (w_gnt[1]) begin
         ram_en    = 1'b1;
         ram_we    = p1_we;
         ram_addr  = p1_addr[ADDR_W+1:2];
         ram_wdata = p1_wdata;
      end else if (w_gnt[2]) begin
         ram_en    = 1'b1;
         ram_addr  = p2_addr[ADDR_W+1:2];
      end
   end

   assign w_rd_push = ram_en & ~ram_we;

   // BOOT -> RUN once; RUN only leaves through reset.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rstn) begin
         r_mode <= MODE_BOOT;
      end else if (r_mode == MODE_BOOT && load_done) begin
         r_mode <= MODE_RUN;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_starve <= '0;
      end else if (w_gnt[2]) begin
         r_starve <= '0;
      end else if (p2_req && (r_starve != STARVE_LIM)) begin
         r_starve <= r_starve + SW'(1);
      end
   end

   // One-hot port tag per granted read, delayed RD_LAT cycles to line up with ram_rdata.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: the tag pipeline is control state, so it is reset; an in-flight read must vanish on reset.
      if (!rstn) begin
         for (int i = 0; i < RD_LAT; i++) r_tag[i] <= 3'b000;
      end else begin
         r_tag[0] <= w_rd_push ? w_gnt : 3'b000;
         for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   assign boot      = (r_mode == MODE_BOOT);

   assign p0_gnt    = w_gnt[0];
   assign p1_gnt    = w_gnt[1];
   assign p2_gnt    = w_gnt[2];

   assign p0_rvalid = r_tag[RD_LAT-1][0];
   assign p1_rvalid = r_tag[RD_LAT-1][1];
   assign p2_rvalid = r_tag[RD_LAT-1][2];

   assign p0_rdata  = ram_rdata;
   assign p1_rdata  = ram_rdata;
   assign p2_rdata  = ram_rdata;

   // Fetch is read-only and addresses above the RAM or below word granularity are dropped.
   assign w_unused  = ^{p2_we, p2_wdata,
                        p0_addr[31:ADDR_W+2], p0_addr[1:0],
                        p1_addr[31:ADDR_W+2], p1_addr[1:0],
                        p2_addr[31:ADDR_W+2], p2_addr[1:0]};

`ifdef ARB_STATS_EN
   logic [31:0] r_stat_gnt1;
   logic [31:0] r_stat_gnt2;
   logic [31:0] r_stat_stall2;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stat_gnt1   <= '0;
         r_stat_gnt2   <= '0;
         r_stat_stall2 <= '0;
      end else begin
         if (w_gnt[1]) r_stat_gnt1 <= r_stat_gnt1 + 32'd1;
         if (w_gnt[2]) r_stat_gnt2 <= r_stat_gnt2 + 32'd1;
         if (p2_req && !w_gnt[2]) r_stat_stall2 <= r_stat_stall2 + 32'd1;
      end
   end

   assign stat_gnt1   = r_stat_gnt1;
   assign stat_gnt2   = r_stat_gnt2;
   assign stat_stall2 = r_stat_stall2;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural block RAM and a read-return scoreboard.
// Define ARB_STATS_EN to also exercise the statistics counters.
module tb_mem_arbiter;

   localparam int ADDR_W     = 15;
   localparam int RD_LAT     = 1;
   localparam int STARVE_MAX = 4;

   typedef struct {
      logic [2:0]  port;
      logic [31:0] data;
      int          due;
   } rd_exp_t;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              load_done = 1'b0;
   logic              boot;
   logic              p0_req = 1'b0, p0_we = 1'b0;
   logic [31:0]       p0_addr = '0, p0_wdata = '0;
   logic              p0_gnt, p0_rvalid;
   logic [31:0]       p0_rdata;
   logic              p1_req = 1'b0, p1_we = 1'b0;
   logic [31:0]       p1_addr = '0, p1_wdata = '0;
   logic              p1_gnt, p1_rvalid;
   logic [31:0]       p1_rdata;
   logic              p2_req = 1'b0, p2_we = 1'b0;
   logic [31:0]       p2_addr = '0, p2_wdata = '0;
   logic              p2_gnt, p2_rvalid;
   logic [31:0]       p2_rdata;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;
`ifdef ARB_STATS_EN
   logic [31:0]       stat_gnt1, stat_gnt2, stat_stall2;
`endif

   int      n_checks = 0;
   int      n_pass   = 0;
   int      cyc      = 0;
   rd_exp_t sb [$];

   mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rstn(rstn), .load_done(load_done), .boot(boot),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_wdata(p2_wdata),
      .p2_gnt(p2_gnt), .p2_rvalid(p2_rvalid), .p2_rdata(p2_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef ARB_STATS_EN
      , .stat_gnt1(stat_gnt1), .stat_gnt2(stat_gnt2), .stat_stall2(stat_stall2)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural single-port RAM with RD_LAT cycles of read latency.
   logic [31:0] mem     [0:(1<<ADDR_W)-1];
   logic [31:0] rd_pipe [RD_LAT];

   always @(posedge clk) begin
      if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
      rd_pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr] : rd_pipe[0];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_rdata = rd_pipe[RD_LAT-1];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      p0_req = 1'b0; p0_we = 1'b0;
      p1_req = 1'b0; p1_we = 1'b0;
      p2_req = 1'b0; p2_we = 1'b0;
   endtask

   // Called at the negedge of the grant cycle.
   task automatic push_rd(input logic [2:0] port, input logic [31:0] data);
      rd_exp_t e;
      e.port = port;
      e.data = data;
      e.due  = cyc + RD_LAT;
      sb.push_back(e);
   endtask

   task automatic p0_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [ADDR_W-1:0] exp_waddr);
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = addr; p0_wdata = data;
      @(negedge clk);
      check("boot_p0_gnt", p0_gnt, 1);
      check("boot_p12_gnt", {p1_gnt, p2_gnt}, 0);
      check("boot_ram_en_we", {ram_en, ram_we}, 2'b11);
      check("boot_ram_addr", ram_addr, exp_waddr);
      check("boot_ram_wdata", ram_wdata, data);
      next_cycle();
      p0_req = 1'b0; p0_we = 1'b0;
   endtask

   // Read-return monitor: every rvalid must match the oldest outstanding read.
   always @(negedge clk) begin
      logic [2:0]  rv;
      logic [31:0] rd;
      rd_exp_t     e;
      if (rstn) begin
         rv = {p2_rvalid, p1_rvalid, p0_rvalid};
         if (rv != 3'b000) begin
            if (sb.size() == 0) begin
               check("rvalid_unexpected", rv, 0);
            end else begin
               e  = sb.pop_front();
               rd = e.port[0] ? p0_rdata : (e.port[1] ? p1_rdata : p2_rdata);
               check("rvalid_port", rv, e.port);
               check("rvalid_cycle", cyc, e.due);
               check("rvalid_data", rd, e.data);
            end
         end else if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            check("rvalid_missing", rv, e.port);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  starve;
      logic exp2;

      // Reset held with every port requesting.
      p0_req = 1'b1; p1_req = 1'b1; p2_req = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_boot", boot, 1);
      check("reset_gnt", {p2_gnt, p1_gnt, p0_gnt}, 0);
      check("reset_ram_en_we", {ram_en, ram_we}, 0);
      check("reset_rvalid", {p2_rvalid, p1_rvalid, p0_rvalid}, 0);
      p0_req = 1'b0;
      next_cycle();
      rstn = 1'b1;

      // BOOT: data and fetch are locked out.
      repeat (3) begin
         @(negedge clk);
         check("boot_no_gnt12", {p1_gnt, p2_gnt}, 0);
         check("boot_flag", boot, 1);
         check("boot_ram_idle", ram_en, 0);
         next_cycle();
      end

      p0_write(32'h0000_0008, 32'hDEAD_BEEF, 15'd2);
      p0_write(32'h0000_0010, 32'h1111_1111, 15'd4);
      p0_write(32'h0000_0014, 32'h2222_2222, 15'd5);
      p0_write(32'h0000_001B, 32'h3333_3333, 15'd6);
      p1_req = 1'b0; p2_req = 1'b0;

      // Last loader read overlaps load_done; its rvalid must still arrive in RUN.
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h8; load_done = 1'b1;
      @(negedge clk);
      check("p0_rd_gnt", p0_gnt, 1);
      check("p0_rd_ram_we", ram_we, 0);
      push_rd(3'b001, 32'hDEAD_BEEF);
      next_cycle();
      p0_req = 1'b0; load_done = 1'b0;
      @(negedge clk);
      check("run_boot_low", boot, 0);

      // RUN: loader ignored, fetch write-enable ignored.
      next_cycle();
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h20;
      p2_req = 1'b1; p2_we = 1'b1; p2_addr = 32'h8;
      @(negedge clk);
      check("run_p2_gnt", p2_gnt, 1);
      check("run_p0_blocked", p0_gnt, 0);
      check("run_p2_ram_we", ram_we, 0);
      check("run_p2_ram_addr", ram_addr, 2);
      push_rd(3'b100, 32'hDEAD_BEEF);
      next_cycle();
      p2_req = 1'b0; p2_we = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("run_p0_never", p0_gnt, 0);
         check("run_ram_idle", ram_en, 0);
         next_cycle();
      end
      p0_req = 1'b0; p0_we = 1'b0;

      load_done = 1'b1;
      next_cycle();
      load_done = 1'b0;
      @(negedge clk);
      check("run_load_done_ignored", boot, 0);
      next_cycle();

      // Starvation: P1 writes and P2 reads requesting every cycle.
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h200; p1_wdata = 32'hA5A5_5A5A;
      p2_req = 1'b1; p2_we = 1'b0; p2_addr = 32'h10;
      starve = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         exp2 = (starve == STARVE_MAX);
         check("starve_p1_gnt", p1_gnt, !exp2);
         check("starve_p2_gnt", p2_gnt, exp2);
         if (exp2) push_rd(3'b100, 32'h1111_1111);
         starve = exp2 ? 0 : ((starve < STARVE_MAX) ? starve + 1 : starve);
         next_cycle();
      end
      idle_all();

      // Alternating reads, then a misaligned P1 read, all back to back.
      for (int i = 0; i < 4; i++) begin
         p1_req = (i % 2 == 0); p1_addr = 32'h10;
         p2_req = (i % 2 == 1); p2_addr = 32'h14;
         @(negedge clk);
         if (i % 2 == 0) begin
            check("alt_p1_gnt", p1_gnt, 1);
            push_rd(3'b010, 32'h1111_1111);
         end else begin
            check("alt_p2_gnt", p2_gnt, 1);
            push_rd(3'b100, 32'h2222_2222);
         end
         next_cycle();
      end
      p2_req = 1'b0;
      p1_req = 1'b1; p1_addr = 32'h19;
      @(negedge clk);
      check("misalign_gnt", p1_gnt, 1);
      check("misalign_ram_addr", ram_addr, 6);
      push_rd(3'b010, 32'h3333_3333);
      next_cycle();
      idle_all();

      for (int i = 0; i < 8; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check("sb_drained", sb.size(), 0);

      // Reset one cycle after a fetch grant drops its rvalid.
      next_cycle();
      p2_req = 1'b1; p2_addr = 32'h8;
      @(negedge clk);
      check("midrd_p2_gnt", p2_gnt, 1);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      p1_req = 1'b1;
      @(negedge clk);
      check("midrd_no_rvalid", p2_rvalid, 0);
      check("midrd_boot", boot, 1);
      check("midrd_gnt", {p2_gnt, p1_gnt, p0_gnt}, 0);
      check("midrd_ram_en", ram_en, 0);
      next_cycle();
      idle_all();
      next_cycle();
      rstn = 1'b1;
      @(negedge clk);
      check("post_reset_boot", boot, 1);
      check("post_reset_rvalid", {p2_rvalid, p1_rvalid, p0_rvalid}, 0);

`ifdef ARB_STATS_EN
      check("stat_reset", {stat_gnt1, stat_gnt2}, 0);
      check("stat_reset_stall", stat_stall2, 0);
      next_cycle();
      load_done = 1'b1;
      next_cycle();
      load_done = 1'b0;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h300;
      p2_req = 1'b1; p2_we = 1'b0; p2_addr = 32'h8;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) p2_req = 1'b0;
         @(negedge clk);
         check("stat_p1_gnt", p1_gnt, 1);
         next_cycle();
      end
      idle_all();
      @(negedge clk);
      check("stat_gnt1", stat_gnt1, 10);
      check("stat_gnt2", stat_gnt2, 0);
      check("stat_stall2", stat_stall2, 3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
